blowfish_ffunc_pipe: RTL and testbench

//  Parametrised, fully pipelined Blowfish F-function engine with a valid/ready handshake on both sides.

---
 rtl/blowfish_pkg.sv | 21 ++
 rtl/blowfish_sbox_ram.sv | 50 +++++
 rtl/blowfish_ffunc_pipe.sv | 97 +++++++++
 tb/tb_blowfish_ffunc_pipe.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/blowfish_pkg.sv
// Shared types and constants for the Blowfish F-function engine.
//   SBOX_DEPTH : entries per S-box
//   WORD_W     : S-box word / lane width
//   NUM_SBOX   : number of S-box banks
//   lane_byte  : picks the S-box address for bank k from a 32-bit lane word
package blowfish_pkg;

  localparam int unsigned SBOX_DEPTH = 256;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned NUM_SBOX   = 4;

  typedef logic [WORD_W-1:0] bf_word_t;
  typedef logic [1:0]        sbox_sel_t;
  typedef logic [7:0]        sbox_addr_t;

  // Bank 0 is addressed by the most significant byte, bank 3 by the least.
  function automatic sbox_addr_t lane_byte(input bf_word_t w, input int unsigned k);
    return w[8*(3-k) +: 8];
  endfunction

endpackage

// File: rtl/blowfish_sbox_ram.sv
// Four 256x32 S-box banks with one shared write port and NUM_SBOX*LANES
// synchronous read ports (port p = lane*NUM_SBOX + bank).
//   clk      : clock
//   rd_en    : read ports capture new data on this edge
//   rd_addr  : per-port read address
//   rd_data  : per-port registered read data
//   wr_en    : write strobe
//   wr_sel   : bank to write
//   wr_addr  : entry to write
//   wr_data  : write data
// A read on the same edge as a write to the same entry returns the old word.
// Contents are not reset.
module blowfish_sbox_ram
  import blowfish_pkg::*;
#(
  parameter int unsigned LANES = 2
) (
  input  logic                                   clk,
  input  logic                                   rd_en,
  input  sbox_addr_t [NUM_SBOX*LANES-1:0]        rd_addr,
  output bf_word_t   [NUM_SBOX*LANES-1:0]        rd_data,
  input  logic                                   wr_en,
  input  sbox_sel_t                              wr_sel,
  input  sbox_addr_t                             wr_addr,
  input  bf_word_t                               wr_data
);

  for (genvar g = 0; g < NUM_SBOX; g++) begin : g_bank
    bf_word_t mem [SBOX_DEPTH];

    always_ff @(posedge clk) begin
      if (wr_en && (wr_sel == sbox_sel_t'(g))) begin
        mem[wr_addr] <= wr_data;
      end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_rd
      bf_word_t rd_q;

      always_ff @(posedge clk) begin
        if (rd_en) begin
          rd_q <= mem[rd_addr[l*NUM_SBOX+g]];
        end
      end

      assign rd_data[l*NUM_SBOX+g] = rd_q;
    end
  end

endmodule

// File: rtl/blowfish_ffunc_pipe.sv
// Fully pipelined Blowfish F-function, LANES independent 32-bit lanes.
//   Clk, RstN          : clock, asynchronous active-low reset
//   InValid/InReady/X  : upstream handshake and input block
//   OutValid/OutReady/Y: downstream handshake and F result
//   SbWrEn/SbSel/SbAddr/SbWrData : S-box load port
//   Busy               : some stage holds a valid transaction
// Y_lane = ((S0[a] + S1[b]) ^ S2[c]) + S3[d] over four register stages.
// The whole pipe shifts together whenever the output is empty or taken.
module blowfish_ffunc_pipe
  import blowfish_pkg::*;
#(
  parameter int unsigned LANES = 2
) (
  input  logic                  Clk,
  input  logic                  RstN,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic [32*LANES-1:0]   X,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic [32*LANES-1:0]   Y,
  input  logic                  SbWrEn,
  input  sbox_sel_t             SbSel,
  input  sbox_addr_t            SbAddr,
  input  bf_word_t              SbWrData,
  output logic                  Busy
);

  logic advance;

  logic st1_valid_q, st2_valid_q, st3_valid_q, st4_valid_q;

  sbox_addr_t [NUM_SBOX*LANES-1:0] rd_addr;
  bf_word_t   [NUM_SBOX*LANES-1:0] rd_data;   // ST1 registers live in the RAM

  bf_word_t [LANES-1:0] st2_a_q, st2_s2_q, st2_s3_q;
  bf_word_t [LANES-1:0] st3_b_q, st3_s3_q;
  bf_word_t [LANES-1:0] st4_y_q;

  assign advance  = ~st4_valid_q | OutReady;
  assign InReady  = advance;
  assign OutValid = st4_valid_q;
  assign Y        = st4_y_q;
  assign Busy     = st1_valid_q | st2_valid_q | st3_valid_q | st4_valid_q;

  always_comb begin
    rd_addr = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      for (int unsigned k = 0; k < NUM_SBOX; k++) begin
        rd_addr[l*NUM_SBOX+k] = lane_byte(X[32*l +: 32], k);
      end
    end
  end

  // Reads are enabled by advance alone; a bubble simply carries junk data.
  blowfish_sbox_ram #(
    .LANES(LANES)
  ) u_sbox_ram (
    .clk     (Clk),
    .rd_en   (advance),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (SbWrEn),
    .wr_sel  (SbSel),
    .wr_addr (SbAddr),
    .wr_data (SbWrData)
  );

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      st1_valid_q <= 1'b0;
      st2_valid_q <= 1'b0;
      st3_valid_q <= 1'b0;
      st4_valid_q <= 1'b0;
      st2_a_q     <= '0;
      st2_s2_q    <= '0;
      st2_s3_q    <= '0;
      st3_b_q     <= '0;
      st3_s3_q    <= '0;
      st4_y_q     <= '0;
    end else if (advance) begin
      st1_valid_q <= InValid;
      st2_valid_q <= st1_valid_q;
      st3_valid_q <= st2_valid_q;
      st4_valid_q <= st3_valid_q;
      for (int unsigned l = 0; l < LANES; l++) begin
        st2_a_q[l]  <= rd_data[l*NUM_SBOX+0] + rd_data[l*NUM_SBOX+1];
        st2_s2_q[l] <= rd_data[l*NUM_SBOX+2];
        st2_s3_q[l] <= rd_data[l*NUM_SBOX+3];
        st3_b_q[l]  <= st2_a_q[l] ^ st2_s2_q[l];
        st3_s3_q[l] <= st2_s3_q[l];
        st4_y_q[l]  <= st3_b_q[l] + st3_s3_q[l];
      end
    end
  end

endmodule

// File: tb/tb_blowfish_ffunc_pipe.sv
// Self-checking bench for blowfish_ffunc_pipe (LANES=2).
// Inputs change 1ns after the rising edge; the monitor samples on the falling edge.
module tb_blowfish_ffunc_pipe;

  localparam int unsigned LANES = 2;
  localparam int unsigned W     = 32 * LANES;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [W-1:0] x, y;
  logic         sb_wr_en;
  logic [1:0]   sb_sel;
  logic [7:0]   sb_addr;
  logic [31:0]  sb_wr_data;

  always #5 clk = ~clk;

  blowfish_ffunc_pipe #(
    .LANES(LANES)
  ) dut (
    .Clk      (clk),
    .RstN     (rst_n),
    .InValid  (in_valid),
    .InReady  (in_ready),
    .X        (x),
    .OutValid (out_valid),
    .OutReady (out_ready),
    .Y        (y),
    .SbWrEn   (sb_wr_en),
    .SbSel    (sb_sel),
    .SbAddr   (sb_addr),
    .SbWrData (sb_wr_data),
    .Busy     (busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0]  sb [4][256];
  logic [W-1:0] exp_q [$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] f_lane(input logic [31:0] w);
    logic [31:0] s0, s1, s2, s3;
    s0 = sb[0][w[31:24]];
    s1 = sb[1][w[23:16]];
    s2 = sb[2][w[15:8]];
    s3 = sb[3][w[7:0]];
    return ((s0 + s1) ^ s2) + s3;
  endfunction

  function automatic logic [W-1:0] f_block(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int l = 0; l < int'(LANES); l++) r[32*l +: 32] = f_lane(v[32*l +: 32]);
    return r;
  endfunction

  // Reference: every accepted block must come out once, in order, with the F value
  // computed from the S-box contents as they were before that accept edge.
  logic         stall_prev = 1'b0;
  logic [W-1:0] y_prev;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      stall_prev = 1'b0;
      chk("reset_outvalid", out_valid, 0);
      chk("reset_busy", busy, 0);
    end else begin
      chk("busy", busy, exp_q.size() != 0);
      if (stall_prev) begin
        chk("stall_outvalid", out_valid, 1);
        chk("stall_y", y, y_prev);
      end
      if (exp_q.size() == 0) chk("outvalid_when_empty", out_valid, 0);
      else if (out_valid && out_ready) chk("y_model", y, exp_q.pop_front());
      if (in_valid && in_ready) exp_q.push_back(f_block(x));
      if (sb_wr_en) sb[sb_sel][sb_addr] = sb_wr_data;
      stall_prev = out_valid && !out_ready;
      y_prev     = y;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_write(input int s, input int a, input logic [31:0] d);
    sb_wr_en   = 1'b1;
    sb_sel     = 2'(s);
    sb_addr    = 8'(a);
    sb_wr_data = d;
    tick();
    sb_wr_en   = 1'b0;
  endtask

  task automatic send_one(input logic [W-1:0] v);
    chk("send_inready", in_ready, 1);
    in_valid = 1'b1;
    x        = v;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  logic [W-1:0] v4 [8] = '{64'h0000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                           64'h0102_0304_0506_0708, 64'hDEAD_BEEF_CAFE_F00D,
                           64'h8000_0001_7FFF_FFFE, 64'hFF01_0000_00FF_0100,
                           64'h1111_2222_3333_4444, 64'hA5A5_5A5A_C3C3_3C3C};

  initial begin
    int           lat;
    int           n;
    logic [15:0]  ov_hist;
    logic         ov_any;

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    x          = '0;
    sb_wr_en   = 1'b0;
    sb_sel     = '0;
    sb_addr    = '0;
    sb_wr_data = '0;
    for (int s = 0; s < 4; s++) for (int i = 0; i < 256; i++) sb[s][i] = '0;

    // T1 reset
    #3;
    chk("t1_outvalid", out_valid, 0);
    chk("t1_busy", busy, 0);
    chk("t1_y", y, 0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("t1_inready", in_ready, 1);

    // T2 identity load
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 256; i++) sb_write(s, i, 32'(i) << (8 * s));
    end
    send_one(64'h1234_5678_ABCD_EF01);
    wait_out(lat);
    chk("t2_latency", lat, 4);
    chk("t2_y", y, 64'h7856_3412_01EF_CDAB);
    tick();

    // T3 carry wrap
    sb_write(0, 8'hFF, 32'hFFFF_FFFF);
    sb_write(1, 8'h01, 32'h0000_0001);
    send_one(64'h0000_0000_FF01_0000);
    wait_out(lat);
    chk("t3_latency", lat, 4);
    chk("t3_y", y, 64'h0);
    tick();

    // T4 throughput
    for (int i = 0; i < 16; i++) begin
      in_valid = (i < 8);
      x        = v4[i % 8];
      tick();
      ov_hist[i] = out_valid;
    end
    in_valid = 1'b0;
    chk("t4_outvalid_window", ov_hist, 16'h07F8);
    chk("t4_busy_idle", busy, 0);

    // T5 backpressure
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      x        = v4[7 - i];
      tick();
    end
    x = v4[2];
    for (int i = 0; i < 3; i++) begin
      chk("t5_inready", in_ready, 0);
      chk("t5_outvalid", out_valid, 1);
      chk("t5_y_head", y, f_block(v4[7]));
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (busy && n < 30) begin
      tick();
      n++;
    end
    chk("t5_drained_busy", busy, 0);
    chk("t5_queue_empty", exp_q.size(), 0);

    // T6 write collision
    sb_wr_en   = 1'b1;
    sb_sel     = 2'd0;
    sb_addr    = 8'h00;
    sb_wr_data = 32'h5;
    in_valid   = 1'b1;
    x          = '0;
    tick();
    sb_wr_en = 1'b0;
    tick();
    in_valid = 1'b0;
    wait_out(lat);
    chk("t6_old_entry", y, 64'h0);
    tick();
    chk("t6_new_valid", out_valid, 1);
    chk("t6_new_entry", y, 64'h0000_0005_0000_0005);
    tick();

    // T6 mid-operation reset
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      x = v4[i + 3];
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("t6_pre_reset_outvalid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_reset_outvalid", out_valid, 0);
    chk("t6_reset_busy", busy, 0);
    tick();
    rst_n  = 1'b1;
    ov_any = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      ov_any |= out_valid;
    end
    chk("t6_no_output_after_reset", ov_any, 0);
    chk("t6_busy_after_reset", busy, 0);
    chk("t6_inready_after_reset", in_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
